// File: rtl/ps2_dir_decoder_pkg.sv
// Shared scan codes, direction encodings and prefix states
// for the PS/2 snake direction decoder.
package ps2_pkg;

  localparam logic [7:0] SC_E0    = 8'hE0;
  localparam logic [7:0] SC_F0    = 8'hF0;
  localparam logic [7:0] SC_W     = 8'h1D;
  localparam logic [7:0] SC_S     = 8'h1B;
  localparam logic [7:0] SC_A     = 8'h1C;
  localparam logic [7:0] SC_D     = 8'h23;
  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_DOWN  = 8'h72;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_RIGHT = 8'h74;

  typedef enum logic [1:0] {
    DIR_UP    = 2'b00,
    DIR_DOWN  = 2'b01,
    DIR_LEFT  = 2'b10,
    DIR_RIGHT = 2'b11
  } dir_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_E0,
    S_F0,
    S_E0F0
  } pfx_state_e;

  typedef struct packed {
    logic hit;
    dir_e dir;
  } dir_hit_t;

  function automatic dir_hit_t wasd_dir(input logic [7:0] b);
    dir_hit_t r;
    r.hit = 1'b1;
    r.dir = DIR_UP;
    unique case (b)
      SC_W:    r.dir = DIR_UP;
      SC_S:    r.dir = DIR_DOWN;
      SC_A:    r.dir = DIR_LEFT;
      SC_D:    r.dir = DIR_RIGHT;
      default: r.hit = 1'b0;
    endcase
    return r;
  endfunction

  function automatic dir_hit_t arrow_dir(input logic [7:0] b);
    dir_hit_t r;
    r.hit = 1'b1;
    r.dir = DIR_UP;
    unique case (b)
      SC_UP:    r.dir = DIR_UP;
      SC_DOWN:  r.dir = DIR_DOWN;
      SC_LEFT:  r.dir = DIR_LEFT;
      SC_RIGHT: r.dir = DIR_RIGHT;
      default:  r.hit = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/ps2_dir_decoder_if.sv
// PS/2 pins plus decoded byte/direction bundle.
// master = decoder side, slave = pin driver / consumer side.
interface ps2_dir_if;
  logic       ps2_clk;
  logic       ps2_data;
  logic [7:0] scan_code;
  logic       code_valid;
  logic       frame_err;
  logic [1:0] dir;
  logic       dir_valid;

  modport master (
    input  ps2_clk, ps2_data,
    output scan_code, code_valid, frame_err,
    output dir, dir_valid
  );

  modport slave (
    output ps2_clk, ps2_data,
    input  scan_code, code_valid, frame_err,
    input  dir, dir_valid
  );
endinterface

// File: rtl/ps2_rx_frame.sv
// PS/2 frame receiver: synchroniser, falling-edge deserialiser,
// start/stop/odd-parity check and mid-frame watchdog.
module ps2_rx_frame
  import ps2_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  output logic [7:0] byte_o,
  output logic       valid_o,
  output logic       err_o
);

  localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WW-1:0] WD_MAX = WW'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0] LAST_BIT = 4'd10;

  logic [SYNC_STAGES-1:0] clk_sync_q, data_sync_q;
  logic        clk_prev_q;
  logic [10:0] sr_q, sr_d, sr_nx;
  logic [3:0]  cnt_q, cnt_d;
  logic [WW-1:0] wd_q, wd_d;
  logic [7:0]  byte_q, byte_d;
  logic        valid_q, valid_d;
  logic        err_q, err_d;
  logic        clk_s, data_s, fall, frame_ok;

  assign clk_s  = clk_sync_q[SYNC_STAGES-1];
  assign data_s = data_sync_q[SYNC_STAGES-1];
  assign fall   = clk_prev_q & ~clk_s;

  always_comb begin
    sr_nx    = {data_s, sr_q[10:1]};
    frame_ok = ~sr_nx[0] & sr_nx[10] & (^sr_nx[9:1]);
    sr_d     = sr_q;
    cnt_d    = cnt_q;
    wd_d     = wd_q;
    byte_d   = byte_q;
    valid_d  = 1'b0;
    err_d    = 1'b0;
    // an edge always beats a coincident watchdog expiry
    if (fall) begin
      sr_d = sr_nx;
      wd_d = '0;
      if (cnt_q == LAST_BIT) begin
        cnt_d = '0;
        if (frame_ok) begin
          byte_d  = sr_nx[8:1];
          valid_d = 1'b1;
        end else begin
          err_d = 1'b1;
        end
      end else begin
        cnt_d = cnt_q + 4'd1;
      end
    end else if (cnt_q != '0) begin
      if (wd_q == WD_MAX) begin
        cnt_d = '0;
        wd_d  = '0;
        err_d = 1'b1;
      end else begin
        wd_d = wd_q + 1'b1;
      end
    end else begin
      wd_d = '0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      clk_sync_q  <= '0;
      data_sync_q <= '0;
      clk_prev_q  <= 1'b0;
      sr_q        <= '0;
      cnt_q       <= '0;
      wd_q        <= '0;
      byte_q      <= '0;
      valid_q     <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      clk_sync_q  <= {clk_sync_q[SYNC_STAGES-2:0], ps2_clk_i};
      data_sync_q <= {data_sync_q[SYNC_STAGES-2:0], ps2_data_i};
      clk_prev_q  <= clk_s;
      sr_q        <= sr_d;
      cnt_q       <= cnt_d;
      wd_q        <= wd_d;
      byte_q      <= byte_d;
      valid_q     <= valid_d;
      err_q       <= err_d;
    end
  end

  assign byte_o  = byte_q;
  assign valid_o = valid_q;
  assign err_o   = err_q;

endmodule

// File: rtl/ps2_dir_decoder.sv
// PS/2 keyboard to snake direction decoder: frame receiver
// plus E0/F0 prefix tracker emitting direction strobes.
module ps2_dir_decoder
  import ps2_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic      clk,
  input  logic      reset,
  ps2_dir_if.master bus
);

  logic [7:0] rx_byte;
  logic       rx_valid, rx_err;

  ps2_rx_frame #(
    .SYNC_STAGES    (SYNC_STAGES),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_rx (
    .clk_i      (clk),
    .rst_i      (reset),
    .ps2_clk_i  (bus.ps2_clk),
    .ps2_data_i (bus.ps2_data),
    .byte_o     (rx_byte),
    .valid_o    (rx_valid),
    .err_o      (rx_err)
  );

  pfx_state_e state_q, state_d;
  dir_e       dir_q, dir_d;
  logic       dv_q, dv_d;
  dir_hit_t   w_hit, a_hit;

  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    dv_d    = 1'b0;
    w_hit   = wasd_dir(rx_byte);
    a_hit   = arrow_dir(rx_byte);
    if (rx_err) begin
      state_d = S_IDLE;
    end else if (rx_valid) begin
      unique case (state_q)
        S_IDLE: begin
          if (rx_byte == SC_E0) begin
            state_d = S_E0;
          end else if (rx_byte == SC_F0) begin
            state_d = S_F0;
          end else if (w_hit.hit) begin
            dir_d = w_hit.dir;
            dv_d  = 1'b1;
          end
        end
        S_E0: begin
          if (rx_byte == SC_F0) begin
            state_d = S_E0F0;
          end else if (rx_byte != SC_E0) begin
            state_d = S_IDLE;
            if (a_hit.hit) begin
              dir_d = a_hit.dir;
              dv_d  = 1'b1;
            end
          end
        end
        // break codes are swallowed here
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      dir_q   <= DIR_UP;
      dv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      dv_q    <= dv_d;
    end
  end

  assign bus.scan_code  = rx_byte;
  assign bus.code_valid = rx_valid;
  assign bus.frame_err  = rx_err;
  assign bus.dir        = dir_q;
  assign bus.dir_valid  = dv_q;

endmodule

// File: tb/tb_ps2_dir_decoder.sv
// Directed bench for ps2_dir_decoder: 1 MHz system clock,
// 60 us PS/2 bit period, watchdog shortened to 200 cycles.
`timescale 1ns/1ps
module tb_ps2_dir_decoder;

  logic clk = 1'b0;
  logic rst = 1'b0;

  ps2_dir_if bus();

  ps2_dir_decoder #(
    .SYNC_STAGES    (2),
    .TIMEOUT_CYCLES (200)
  ) dut (
    .clk   (clk),
    .reset (rst),
    .bus   (bus)
  );

  always #500 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  int cv_n = 0, fe_n = 0, dv_n = 0;
  int cv_cyc = 0, dv_cyc = 0;
  bit both = 1'b0;
  int c0, f0, d0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.code_valid) begin
      cv_n++;
      cv_cyc = cyc;
    end
    if (bus.frame_err) fe_n++;
    if (bus.dir_valid) begin
      dv_n++;
      dv_cyc = cyc;
    end
    if (bus.code_valid && bus.frame_err) both = 1'b1;
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [10:0] mkf(input logic [7:0] b,
                                      input logic bad);
    return {1'b1, ~(^b) ^ bad, b, 1'b0};
  endfunction

  task automatic send_bits(input logic [10:0] f, input int n);
    for (int i = 0; i < n; i++) begin
      bus.ps2_data = f[i];
      #15us;
      bus.ps2_clk = 1'b0;
      #30us;
      bus.ps2_clk = 1'b1;
      #15us;
    end
    bus.ps2_data = 1'b1;
  endtask

  task automatic send(input logic [7:0] b);
    send_bits(mkf(b, 1'b0), 11);
    #20us;
  endtask

  task automatic snap();
    c0 = cv_n;
    f0 = fe_n;
    d0 = dv_n;
  endtask

  initial begin
    bus.ps2_clk  = 1'b1;
    bus.ps2_data = 1'b1;
    #1;
    rst = 1'b1;
    #3us;
    chk("rst_code", bus.scan_code, 0);
    chk("rst_cv", bus.code_valid, 0);
    chk("rst_fe", bus.frame_err, 0);
    chk("rst_dir", bus.dir, 0);
    chk("rst_dv", bus.dir_valid, 0);
    rst = 1'b0;
    #5us;

    snap();
    send(8'h1D);
    chk("t1_cv", cv_n - c0, 1);
    chk("t1_code", bus.scan_code, 8'h1D);
    chk("t1_dv", dv_n - d0, 1);
    chk("t1_dir", bus.dir, 2'b00);
    chk("t1_lat", dv_cyc - cv_cyc, 1);

    snap();
    send(8'hE0);
    send(8'h6B);
    chk("t2_dv", dv_n - d0, 1);
    chk("t2_dir", bus.dir, 2'b10);
    snap();
    send(8'hE0);
    send(8'hF0);
    send(8'h6B);
    chk("t2_brk_cv", cv_n - c0, 3);
    chk("t2_brk_dv", dv_n - d0, 0);
    chk("t2_brk_dir", bus.dir, 2'b10);
    snap();
    send(8'h1B);
    chk("t2_idle_dv", dv_n - d0, 1);
    chk("t2_idle_dir", bus.dir, 2'b01);

    snap();
    send_bits(mkf(8'h23, 1'b1), 11);
    #20us;
    chk("t3_fe", fe_n - f0, 1);
    chk("t3_cv", cv_n - c0, 0);
    chk("t3_code", bus.scan_code, 8'h1B);
    chk("t3_dir", bus.dir, 2'b01);
    chk("t3_dv", dv_n - d0, 0);

    snap();
    send_bits(mkf(8'h55, 1'b0), 5);
    #400us;
    chk("t4_fe", fe_n - f0, 1);
    chk("t4_cv", cv_n - c0, 0);
    snap();
    send(8'hE0);
    send(8'h72);
    chk("t4_cv2", cv_n - c0, 2);
    chk("t4_code", bus.scan_code, 8'h72);
    chk("t4_dv", dv_n - d0, 1);
    chk("t4_dir", bus.dir, 2'b01);
    chk("t4_fe2", fe_n - f0, 0);

    snap();
    send(8'hF0);
    send(8'h1C);
    chk("t5_brk_dv", dv_n - d0, 0);
    send(8'h1C);
    chk("t5_dv", dv_n - d0, 1);
    chk("t5_dir", bus.dir, 2'b10);
    send(8'h1C);
    chk("t5_rep", dv_n - d0, 2);

    send_bits(mkf(8'h75, 1'b0), 6);
    #10us;
    rst = 1'b1;
    #3us;
    chk("t6_code", bus.scan_code, 0);
    chk("t6_dir", bus.dir, 0);
    chk("t6_cv", bus.code_valid, 0);
    chk("t6_fe", bus.frame_err, 0);
    chk("t6_dv", bus.dir_valid, 0);
    rst = 1'b0;
    #20us;
    snap();
    send(8'h75);
    chk("t6_cv2", cv_n - c0, 1);
    chk("t6_code2", bus.scan_code, 8'h75);
    chk("t6_fe2", fe_n - f0, 0);
    chk("t6_dv2", dv_n - d0, 0);
    send(8'hE0);
    send(8'h75);
    chk("t6_dv3", dv_n - d0, 1);
    chk("t6_dir3", bus.dir, 2'b00);

    chk("excl", both, 0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
